clk_divider_multi: RTL and testbench
====================================

Name: clk_divider_multi

Overview:
- Parametrised successor to the fixed single-output clock divider.
- Generates NUM_CH independent divided clock-enable/square-wave outputs from one system clock.
- Each channel has a runtime-programmable divisor, a glitch-free divisor update at period boundaries, per-channel enable, a common phase-sync restart, and a one-cycle tick pulse.
- Sits between the board clock and the timekeeping/display/alarm logic (1 Hz seconds tick, display mux rate, buzzer tone).

Parameters:
- NUM_CH, 4, number of independent divider channels (1..16).
- WIDTH, 16, divisor and counter width in bits.
- DEFAULT_DIV, 2, divisor loaded into every channel at reset (must be >= 2).

Ports:
- clkin  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- cfg_we  input  1  divisor write strobe, one cycle.
- cfg_sel  input  $clog2(NUM_CH) (min 1)  channel selected by cfg_we.
- cfg_div  input  WIDTH  divisor value to write.
- ch_en  input  NUM_CH  per-channel enable, level.
- sync  input  1  one-cycle pulse that restarts all enabled channels in phase.
- clkout  output  NUM_CH  divided square wave per channel.
- tick  output  NUM_CH  one-cycle pulse at the start of each channel period.
- cur_div  output  NUM_CH*WIDTH  active divisor per channel, channel c at bits [c*WIDTH +: WIDTH].

Behaviour:
- Reset (synchronous, while reset=1 at a clkin edge), for every channel:
  - cnt=0; act_div=pend_div=DEFAULT_DIV; clkout=0; tick=0.
  - reset overrides cfg_we and sync in the same cycle.
- Per-channel state: cnt[WIDTH], act_div[WIDTH], pend_div[WIDTH], upd flag.
- Config write: cfg_we=1 sets pend_div[cfg_sel]<=cfg_div and upd<=1.
  - cfg_sel >= NUM_CH: write ignored.
  - A second write before the boundary overwrites pend_div; last write wins.
- Counting, when ch_en[c]=1 and act_div>=2:
  - cnt==act_div-1 (period boundary): cnt<=0; if upd, act_div<=pend_div and upd<=0.
  - Otherwise: cnt<=cnt+1.
- Outputs are registered, zero combinational paths from inputs:
  - hi = (act_div+1)>>1, computed in WIDTH+1 bits.
  - clkout[c] <= (cnt_next < hi_next).
  - tick[c] <= (cnt_next == 0) && counting.
  - Result: period = act_div cycles; high time = ceil(act_div/2); low time = floor(act_div/2). Duty is 50% for even divisors; odd divisors are high one extra cycle.
- First period after reset/enable/sync: clkout and tick rise on the cycle after the start event.
- Divisor 0 or 1 (held in act_div):
  - 0: channel halted; cnt=0, clkout=0, tick=0.
  - 1: clkout=1 and tick=1 every enabled cycle.
- ch_en[c]=0:
  - cnt, clkout and tick forced to 0 on the next edge.
  - A pending update is applied immediately: act_div<=pend_div, upd<=0.
  - Re-enable starts a fresh period from cnt=0.
- sync=1:
  - Every enabled channel: cnt<=0, pending update applied, clkout<=1 (if act_div>=1), tick<=1.
  - Takes priority over the normal boundary in the same cycle.
  - cfg_we in the same cycle still latches pend_div, and that write is also applied.
- Counter never exceeds act_div-1.
  - act_div changes only at a boundary, enable-off, or sync, so no wrap past 2^WIDTH-1 is possible.
  - Max divisor is 2^WIDTH-1.
- cur_div reflects act_div (not pend_div), registered.

Test Plan:
- Reset, ch_en=4'b0001, DEFAULT_DIV=2 -> clkout[0] toggles every cycle (period 2); tick[0] every 2nd cycle; other channels stay 0; cur_div[15:0]=2.
- Write ch1 div=5, enable ch1 -> period 5, clkout[1] high 3 cycles / low 2 cycles, tick[1] once per 5 cycles; cur_div ch1=5.
- Ch0 running div=4, write div=6 at cnt=1 -> current period completes 4 cycles (high 2 / low 2) before changing; next period is 6 cycles (high 3 / low 3); cur_div updates at the boundary; no runt pulse.
- Ch0 div=4, ch1 div=8, both enabled, assert sync mid-period -> both counters restart; both tick on the same cycle; rising edges of clkout[0] and clkout[1] stay aligned every 8 cycles.
- Write div=0 to ch2 -> clkout[2]/tick[2] stay 0. Write div=1 -> clkout[2]=1 and tick[2]=1 every cycle. Write cfg_sel=7 with NUM_CH=4 -> no state change.
- Assert reset mid-period with cfg_we and sync also high -> next cycle all outputs 0, all divisors = DEFAULT_DIV, pending write discarded.

Source files
------------

// File: rtl/clk_divider_multi.sv
// clk_divider_multi
//   NUM_CH independent programmable clock dividers running off one clock.
//   Each channel produces a square wave (high for ceil(div/2) cycles, low for
//   floor(div/2) cycles) and a one-cycle tick at the start of every period.
//   A new divisor is held as pending and only takes effect at a period
//   boundary, when the channel is disabled, or on a sync pulse. This keeps
//   the outputs free of runt pulses.
//
// Ports
//   clkin    system clock, rising edge
//   reset    synchronous active-high reset
//   cfg_we   divisor write strobe (one cycle)
//   cfg_sel  channel addressed by cfg_we; out-of-range values are ignored
//   cfg_div  divisor to write (0 halts the channel, 1 gives a constant high)
//   ch_en    per-channel enable (level)
//   sync     one-cycle pulse that restarts all enabled channels in phase
//   clkout   divided square wave per channel (registered)
//   tick     period-start pulse per channel (registered)
//   cur_div  active divisor per channel, channel c at [c*WIDTH +: WIDTH]
module clk_divider_multi #(
  parameter int NUM_CH      = 4,
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                                           clkin,
  input  logic                                           reset,
  input  logic                                           cfg_we,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_sel,
  input  logic [WIDTH-1:0]                               cfg_div,
  input  logic [NUM_CH-1:0]                              ch_en,
  input  logic                                           sync,
  output logic [NUM_CH-1:0]                              clkout,
  output logic [NUM_CH-1:0]                              tick,
  output logic [NUM_CH*WIDTH-1:0]                        cur_div
);

  localparam int              SELW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [WIDTH-1:0] DEF = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] act_q;
    logic [WIDTH-1:0] pend_q;
    logic             upd_q;
    logic             run_q;
    logic             clk_q;
    logic             tick_q;

    logic             wr;
    logic             upd_eff;
    logic             restart;
    logic             live;
    logic [WIDTH-1:0] pend_eff;
    logic [WIDTH-1:0] act_new;
    logic [WIDTH-1:0] act_nxt;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH:0]   hi;

    // A write in the same cycle as a restart is folded in, so a write that
    // coincides with sync (or enable-off) takes effect immediately.
    assign wr       = cfg_we && (cfg_sel == SELW'(c));
    assign pend_eff = wr ? cfg_div : pend_q;
    assign upd_eff  = wr || upd_q;
    assign act_new  = upd_eff ? pend_eff : act_q;

    // Every event that starts a fresh period: disabled, sync, first enabled
    // cycle, halted (div 0, so a later write can wake it), or the boundary.
    assign restart = !ch_en[c] || sync || !run_q || (act_q == '0) ||
                     (cnt_q == act_q - ONE);
    assign cnt_nxt = restart ? '0 : cnt_q + ONE;
    assign act_nxt = restart ? act_new : act_q;
    assign hi      = ({1'b0, act_nxt} + (WIDTH+1)'(1)) >> 1;
    assign live    = ch_en[c] && (act_nxt != '0);

    always_ff @(posedge clkin) begin
      if (reset) begin
        cnt_q  <= '0;
        act_q  <= DEF;
        pend_q <= DEF;
        upd_q  <= 1'b0;
        run_q  <= 1'b0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_nxt;
        act_q  <= act_nxt;
        pend_q <= pend_eff;
        upd_q  <= upd_eff && !restart;
        run_q  <= ch_en[c];
        clk_q  <= live && ({1'b0, cnt_nxt} < hi);
        tick_q <= live && (cnt_nxt == '0);
      end
    end

    assign clkout[c]                 = clk_q;
    assign tick[c]                   = tick_q;
    assign cur_div[c*WIDTH +: WIDTH] = act_q;
  end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Directed bench for clk_divider_multi, built with five channels so that a
// 3-bit cfg_sel can address a channel that does not exist (5..7).
module tb_clk_divider_multi;

  localparam int NCH = 5;
  localparam int W   = 16;

  logic            clkin = 1'b0;
  logic            reset;
  logic            cfg_we;
  logic [2:0]      cfg_sel;
  logic [W-1:0]    cfg_div;
  logic [NCH-1:0]  ch_en;
  logic            sync;
  logic [NCH-1:0]  clkout;
  logic [NCH-1:0]  tick;
  logic [NCH*W-1:0] cur_div;

  int checks = 0;
  int errors = 0;

  clk_divider_multi #(.NUM_CH(NCH), .WIDTH(W), .DEFAULT_DIV(2)) dut (
    .clkin   (clkin),
    .reset   (reset),
    .cfg_we  (cfg_we),
    .cfg_sel (cfg_sel),
    .cfg_div (cfg_div),
    .ch_en   (ch_en),
    .sync    (sync),
    .clkout  (clkout),
    .tick    (tick),
    .cur_div (cur_div)
  );

  always #5 clkin = ~clkin;

  typedef struct {
    logic [NCH-1:0] en;
    logic           we;
    logic [2:0]     sel;
    logic [W-1:0]   div;
    logic           syn;
    logic [NCH-1:0] eclk;
    logic [NCH-1:0] etick;
    int             dch;
    logic [W-1:0]   ediv;
  } vec_t;

  vec_t vt[17];

  task automatic step();
    @(posedge clkin);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] divof(input int c);
    return cur_div[c*W +: W];
  endfunction

  task automatic idle();
    cfg_we = 1'b0; cfg_sel = '0; cfg_div = '0; sync = 1'b0;
  endtask

  initial begin
    logic [10:0] pclk;
    logic [10:0] ptick;

    // en, we, sel, div, sync, exp clkout, exp tick, div channel, exp div
    vt[0]  = '{5'b00001, 1'b0, 3'd0, 16'd0, 1'b0, 5'b00001, 5'b00001, 0, 16'd2};
    vt[1]  = '{5'b00001, 1'b0, 3'd0, 16'd0, 1'b0, 5'b00000, 5'b00000, 0, 16'd2};
    vt[2]  = '{5'b00001, 1'b0, 3'd0, 16'd0, 1'b0, 5'b00001, 5'b00001, 0, 16'd2};
    vt[3]  = '{5'b00001, 1'b0, 3'd0, 16'd0, 1'b0, 5'b00000, 5'b00000, 0, 16'd2};
    vt[4]  = '{5'b00001, 1'b1, 3'd1, 16'd5, 1'b0, 5'b00001, 5'b00001, 1, 16'd5};
    vt[5]  = '{5'b00011, 1'b0, 3'd0, 16'd0, 1'b0, 5'b00010, 5'b00010, 1, 16'd5};
    vt[6]  = '{5'b00011, 1'b0, 3'd0, 16'd0, 1'b0, 5'b00011, 5'b00001, 0, 16'd2};
    vt[7]  = '{5'b00011, 1'b0, 3'd0, 16'd0, 1'b0, 5'b00010, 5'b00000, 1, 16'd5};
    vt[8]  = '{5'b00011, 1'b0, 3'd0, 16'd0, 1'b0, 5'b00001, 5'b00001, 0, 16'd2};
    vt[9]  = '{5'b00011, 1'b0, 3'd0, 16'd0, 1'b0, 5'b00000, 5'b00000, 1, 16'd5};
    vt[10] = '{5'b00011, 1'b0, 3'd0, 16'd0, 1'b0, 5'b00011, 5'b00011, 0, 16'd2};
    vt[11] = '{5'b00011, 1'b1, 3'd7, 16'd9, 1'b0, 5'b00010, 5'b00000, 3, 16'd2};
    vt[12] = '{5'b00111, 1'b1, 3'd2, 16'd0, 1'b0, 5'b00011, 5'b00001, 2, 16'd0};
    vt[13] = '{5'b00111, 1'b0, 3'd0, 16'd0, 1'b0, 5'b00000, 5'b00000, 2, 16'd0};
    vt[14] = '{5'b00111, 1'b1, 3'd2, 16'd1, 1'b0, 5'b00101, 5'b00101, 2, 16'd1};
    vt[15] = '{5'b00111, 1'b0, 3'd0, 16'd0, 1'b0, 5'b00110, 5'b00110, 1, 16'd5};
    vt[16] = '{5'b00111, 1'b0, 3'd0, 16'd0, 1'b0, 5'b00111, 5'b00101, 2, 16'd1};

    // Reset state
    reset = 1'b1; ch_en = '0; idle();
    step(); step();
    chk("reset clkout", 32'(clkout), 32'h0);
    chk("reset tick", 32'(tick), 32'h0);
    for (int c = 0; c < NCH; c++) chk($sformatf("reset cur_div ch%0d", c), 32'(divof(c)), 32'd2);
    reset = 1'b0;

    // Table: default divisor, div 5, out-of-range select, div 0 and div 1
    for (int i = 0; i < 17; i++) begin
      ch_en = vt[i].en; cfg_we = vt[i].we; cfg_sel = vt[i].sel;
      cfg_div = vt[i].div; sync = vt[i].syn;
      step();
      chk($sformatf("vec%0d clkout", i), 32'(clkout), 32'(vt[i].eclk));
      chk($sformatf("vec%0d tick", i), 32'(tick), 32'(vt[i].etick));
      chk($sformatf("vec%0d cur_div ch%0d", i, vt[i].dch), 32'(divof(vt[i].dch)), 32'(vt[i].ediv));
    end
    idle();

    // Divisor change mid-period: ch0 div 4, write 6 when cnt==1
    reset = 1'b1; ch_en = '0; step(); reset = 1'b0;
    cfg_we = 1'b1; cfg_sel = 3'd0; cfg_div = 16'd4; step(); idle();
    ch_en = 5'b00001;
    pclk  = 11'b10001110011;   // bit i = expected clkout[0] after edge i+1
    ptick = 11'b10000010001;
    for (int i = 0; i < 11; i++) begin
      if (i == 2) begin cfg_we = 1'b1; cfg_sel = 3'd0; cfg_div = 16'd6; end
      step();
      idle();
      chk($sformatf("upd e%0d clkout0", i+1), 32'(clkout[0]), 32'(pclk[i]));
      chk($sformatf("upd e%0d tick0", i+1), 32'(tick[0]), 32'(ptick[i]));
      chk($sformatf("upd e%0d cur_div0", i+1), 32'(divof(0)), (i >= 4) ? 32'd6 : 32'd4);
    end

    // Phase sync: ch0 div 4, ch1 div 8, started out of phase
    reset = 1'b1; ch_en = '0; step(); reset = 1'b0;
    cfg_we = 1'b1; cfg_sel = 3'd0; cfg_div = 16'd4; step();
    cfg_sel = 3'd1; cfg_div = 16'd8; step(); idle();
    ch_en = 5'b00010; step(); step(); step();
    ch_en = 5'b00011; step(); step();
    sync = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      step();
      sync = 1'b0;
      chk($sformatf("sync k%0d clkout", k), 32'(clkout[1:0]),
          32'({((k % 8) < 4), ((k % 4) < 2)}));
      chk($sformatf("sync k%0d tick", k), 32'(tick[1:0]),
          32'({((k % 8) == 0), ((k % 4) == 0)}));
    end

    // Reset mid-period with a write and sync in the same cycle
    step(); step();
    reset = 1'b1; cfg_we = 1'b1; cfg_sel = 3'd0; cfg_div = 16'd10; sync = 1'b1;
    step();
    reset = 1'b0; idle(); ch_en = 5'b00001;
    chk("rst2 clkout", 32'(clkout), 32'h0);
    chk("rst2 tick", 32'(tick), 32'h0);
    for (int c = 0; c < NCH; c++) chk($sformatf("rst2 cur_div ch%0d", c), 32'(divof(c)), 32'd2);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("rst2 e%0d clkout0", i+1), 32'(clkout[0]), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("rst2 e%0d cur_div0", i+1), 32'(divof(0)), 32'd2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
